mem_port_arbiter: RTL and testbench

- Shares the single 16-bit memory port (combinational read, write on posedge clk) between two masters: port 0 is the Temple CPU, port 1 is a secondary master such as a program loader, DMA or debug agent.
- Round-robin arbitration with an optional bus lock, a bounded burst length, and per-port saturating wait counters for performance observation.
- Sits between the masters and the memory model in the top-level/testfix integration.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single 16-bit memory port: round-robin with bus lock,
// bounded burst length and saturating per-port wait counters.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  wait0_cnt,
    output logic [CNT_W-1:0]  wait1_cnt
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last;
    logic [BW-1:0] burst_cnt;
    logic          burst_at_last;

    assign burst_at_last = (burst_cnt == BURST_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
                else
                    state_nxt = IDLE;
            end
            OWN0: begin
                // A locked owner still yields once its burst is used up and the other side waits.
                if (req0 && lock0 && !(req1 && burst_at_last))
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else
                    state_nxt = IDLE;
            end
            OWN1: begin
                if (req1 && lock1 && !(req0 && burst_at_last))
                    state_nxt = OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == OWN0)
                last <= 1'b0;
            else if (state_nxt == OWN1)
                last <= 1'b1;
            if (state_nxt != IDLE && state_nxt == state) begin
                if (!burst_at_last)
                    burst_cnt <= burst_cnt + BW'(1);
            end else begin
                burst_cnt <= '0;
            end
        end
    end

    // Port mux stays combinational so a granted master completes in the grant cycle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        case (state)
            OWN0: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_wen   = we0 && req0 && !rst;
                ack0      = req0;
                rdata0    = (req0 && !we0) ? mem_rdata : '0;
            end
            OWN1: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_wen   = we1 && req1 && !rst;
                ack1      = req1;
                rdata1    = (req1 && !we1) ? mem_rdata : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait0_cnt <= '0;
            wait1_cnt <= '0;
        end else begin
            if (req0 && !ack0 && (wait0_cnt != '1))
                wait0_cnt <= wait0_cnt + CNT_W'(1);
            if (req1 && !ack1 && (wait1_cnt != '1))
                wait1_cnt <= wait1_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected acks, a negedge
// monitor matches them against the DUT; a second instance exercises counter saturation.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, lock0, ack0;
    logic [15:0] addr0, wdata0, rdata0;
    logic        req1, we1, lock1, ack1;
    logic [15:0] addr1, wdata1, rdata1;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen;
    logic [15:0] wait0_cnt, wait1_cnt;

    logic        s_rst, s_req0, s_lock0, s_req1;
    logic        s_ack0, s_ack1, s_mem_wen;
    logic [15:0] s_rdata0, s_rdata1, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_wait0, s_wait1;

    logic [7:0]  mem [0:65535];
    logic [15:0] mem_addr_p1;
    int          cyc;
    int          checks;
    int          errors;

    typedef struct {
        int          port;
        int          cyc;
        logic        we;
        logic [15:0] addr;
        logic [15:0] rdata;
    } exp_t;
    exp_t sbq[$];

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .ack1(ack1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata),
        .wait0_cnt(wait0_cnt), .wait1_cnt(wait1_cnt)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(20), .CNT_W(4)) u_sat (
        .clk(clk), .rst(s_rst),
        .req0(s_req0), .we0(1'b0), .addr0(16'h0000), .wdata0(16'h0000), .lock0(s_lock0),
        .ack0(s_ack0), .rdata0(s_rdata0),
        .req1(s_req1), .we1(1'b0), .addr1(16'h0000), .wdata1(16'h0000), .lock1(1'b0),
        .ack1(s_ack1), .rdata1(s_rdata1),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_wen(s_mem_wen),
        .mem_rdata(16'h0000),
        .wait0_cnt(s_wait0), .wait1_cnt(s_wait1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[1000] = 8'h09;
        mem[1001] = 8'h00;
        mem[1004] = 8'hBE;
        mem[1005] = 8'hEF;
    end

    // Little-endian byte memory: word at addr is {mem[addr+1], mem[addr]}.
    assign mem_addr_p1 = mem_addr + 16'd1;
    assign mem_rdata   = {mem[mem_addr_p1], mem[mem_addr]};

    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr]    = mem_wdata[7:0];
            mem[mem_addr_p1] = mem_wdata[15:8];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    exp_t        m_e;
    int          m_port;
    logic [15:0] m_rd;
    logic [15:0] m_exp_rd;

    always @(negedge clk) begin
        if (!rst && (ack0 || ack1)) begin
            checks++;
            if (ack0 && ack1) begin
                errors++;
                $display("FAIL dual_ack: ack0=%0b ack1=%0b, required at most one", ack0, ack1);
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: port %0d acked at cycle %0d, required no ack", ack1 ? 1 : 0, cyc);
            end else begin
                m_e      = sbq.pop_front();
                m_port   = ack1 ? 1 : 0;
                m_rd     = ack1 ? rdata1 : rdata0;
                m_exp_rd = m_e.we ? 16'h0000 : m_e.rdata;
                if (m_port != m_e.port || cyc != m_e.cyc || mem_wen != m_e.we ||
                    mem_addr != m_e.addr || m_rd != m_exp_rd) begin
                    errors++;
                    $display("FAIL ack_match: got port=%0d cyc=%0d wen=%0b addr=%0d rdata=%h, required port=%0d cyc=%0d wen=%0b addr=%0d rdata=%h",
                             m_port, cyc, mem_wen, mem_addr, m_rd,
                             m_e.port, m_e.cyc, m_e.we, m_e.addr, m_exp_rd);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input int c, input logic w, input logic [15:0] a,
                        input logic [15:0] rd);
        exp_t e;
        e.port = p; e.cyc = c; e.we = w; e.addr = a; e.rdata = rd;
        sbq.push_back(e);
    endtask

    // Raise a request and hold it until acked; returns just after the following posedge.
    task automatic access(input int p, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic lk);
        int n;
        logic seen;
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; lock0 = lk;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; lock1 = lk;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = (p == 0) ? ack0 : ack1;
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: port %0d no ack within 50 cycles, required ack", p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_port(input int p);
        if (p == 0) begin
            req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = '0; wdata0 = '0;
        end else begin
            req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = '0; wdata1 = '0;
        end
    endtask

    task automatic do_reset();
        release_port(0);
        release_port(1);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int t;

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        s_rst  = 1'b1;
        s_req0 = 1'b0; s_lock0 = 1'b0; s_req1 = 1'b0;
        release_port(0);
        release_port(1);

        // Reset, then idle
        @(posedge clk);
        #1;
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        do_reset();
        @(negedge clk);
        chk("idle_acks", {30'd0, ack1, ack0}, 32'd0);
        chk("idle_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("idle_mem_wdata_wen", {15'd0, mem_wdata, mem_wen}, 32'd0);
        chk("idle_rdata", {rdata1, rdata0}, 32'd0);
        chk("idle_waits", {wait1_cnt, wait0_cnt}, 32'd0);
        @(posedge clk);
        #1;

        // Single read by port 0, acked one cycle after the request
        t = cyc;
        push(0, t + 1, 1'b0, 16'd1000, 16'h0009);
        access(0, 1'b0, 16'd1000, 16'h0000, 1'b0);
        release_port(0);
        @(negedge clk);
        chk("read_wait0", {16'd0, wait0_cnt}, 32'd1);
        @(posedge clk);
        #1;

        // Simultaneous writes from IDLE: port 0 first after reset
        do_reset();
        t = cyc;
        push(0, t + 1, 1'b1, 16'd1000, 16'h0000);
        push(1, t + 2, 1'b1, 16'd1002, 16'h0000);
        fork
            begin access(0, 1'b1, 16'd1000, 16'hAAAA, 1'b0); release_port(0); end
            begin access(1, 1'b1, 16'd1002, 16'h5555, 1'b0); release_port(1); end
        join
        @(negedge clk);
        chk("wr_mem1000", {16'd0, mem[1001], mem[1000]}, 32'h0000AAAA);
        chk("wr_mem1002", {16'd0, mem[1003], mem[1002]}, 32'h00005555);
        chk("wr_waits", {wait1_cnt, wait0_cnt}, {16'd2, 16'd1});
        @(posedge clk);
        #1;

        // Locked port 1 burst capped at 4 while port 0 waits
        do_reset();
        t = cyc;
        for (int i = 1; i <= 4; i++) push(1, t + i, 1'b1, 16'(2000 + 2 * (i - 1)), 16'h0000);
        push(0, t + 5, 1'b0, 16'd1002, 16'h5555);
        push(1, t + 6, 1'b1, 16'd2008, 16'h0000);
        fork
            begin
                for (int i = 0; i < 5; i++)
                    access(1, 1'b1, 16'(2000 + 2 * i), 16'(16'h1000 + i), 1'b1);
                release_port(1);
            end
            begin
                @(posedge clk);
                #1;
                access(0, 1'b0, 16'd1002, 16'h0000, 1'b0);
                release_port(0);
            end
        join
        @(negedge clk);
        chk("burst_mem2006", {16'd0, mem[2007], mem[2006]}, 32'h00001003);
        chk("burst_mem2008", {16'd0, mem[2009], mem[2008]}, 32'h00001004);
        chk("burst_waits", {wait1_cnt, wait0_cnt}, {16'd2, 16'd4});
        @(posedge clk);
        #1;

        // Reset in the middle of a port 1 write
        do_reset();
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd1004; wdata1 = 16'h1234;
        @(posedge clk);
        #1;
        chk("midwr_wen_before", {31'd0, mem_wen}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midwr_wen_dropped", {31'd0, mem_wen}, 32'd0);
        chk("midwr_ack1_dropped", {31'd0, ack1}, 32'd0);
        release_port(1);
        @(posedge clk);
        #1;
        chk("midwr_mem_unchanged", {16'd0, mem[1005], mem[1004]}, 32'h0000EFBE);
        rst = 1'b0;
        @(negedge clk);
        chk("midwr_idle_outputs", {14'd0, ack1, ack0, mem_addr}, 32'd0);
        chk("midwr_waits", {wait1_cnt, wait0_cnt}, 32'd0);
        @(posedge clk);
        #1;
        t = cyc;
        push(0, t + 1, 1'b0, 16'd1000, 16'hAAAA);
        push(1, t + 2, 1'b0, 16'd1002, 16'h5555);
        fork
            begin access(0, 1'b0, 16'd1000, 16'h0000, 1'b0); release_port(0); end
            begin access(1, 1'b0, 16'd1002, 16'h0000, 1'b0); release_port(1); end
        join
        @(posedge clk);
        #1;

        // Wait counter saturation on a 4-bit counter with port 0 locked
        s_rst = 1'b0;
        s_req0 = 1'b1; s_lock0 = 1'b1; s_req1 = 1'b1;
        for (int i = 0; i < 5; i++) @(posedge clk);
        @(negedge clk);
        chk("sat_wait1_mid", {28'd0, s_wait1}, 32'd5);
        for (int i = 0; i < 15; i++) @(posedge clk);
        @(negedge clk);
        chk("sat_wait1_cap", {28'd0, s_wait1}, 32'd15);
        chk("sat_owner", {30'd0, s_ack1, s_ack0}, 32'd1);
        chk("sat_wait0", {28'd0, s_wait0}, 32'd1);
        s_req0 = 1'b0; s_lock0 = 1'b0; s_req1 = 1'b0;

        chk("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
